load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the single-cycle RV32I core.
- Takes the ALU result as the effective address and Rs2 as store data, and runs a request/acknowledge transaction on the data-memory bus.
- Produces byte enables and lane-aligned write data for stores, and sign- or zero-extended load data for writeback.
- Stalls the core (PC and register-file write frozen) until the bus transaction completes.

Parameters:
- XLEN, 32, datapath and address width.
- TIMEOUT, 16, maximum REQ-state cycles to wait for Bus_Ack before aborting (must be >= 2).

Ports:
- CLK  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Mem_Req  input  1  current instruction is a load or store.
- Mem_Write  input  1  1 = store, 0 = load.
- Funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- Addr  input  XLEN  effective address (ALU Result).
- Store_Data  input  XLEN  Rs2 value.
- Stall  output  1  freeze core this cycle.
- Load_Data  output  XLEN  extended load result.
- Load_Valid  output  1  Load_Data valid (one-cycle pulse).
- Bus_Err  output  1  transaction timed out (one-cycle pulse).
- Misaligned  output  1  misaligned access detected (only with the optional feature).
- Bus_Req  output  1  bus request.
- Bus_We  output  1  bus write enable.
- Bus_Addr  output  XLEN  word-aligned bus address; bits [1:0] are always 0.
- Bus_Be  output  4  byte enables.
- Bus_Wdata  output  XLEN  lane-replicated write data.
- Bus_Ack  input  1  bus completion, sampled on the rising edge.
- Bus_Rdata  input  XLEN  read data, valid when Bus_Ack = 1.

Behaviour:
- Reset values: state IDLE; Bus_Req, Bus_We, Bus_Be, Bus_Addr, Bus_Wdata, Load_Data, Load_Valid, Bus_Err, Misaligned all 0; timeout counter 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Stall = Mem_Req, combinational.
  - When Mem_Req = 1 (and the access is not trapped), register the following and go to REQ:
    - Bus_Addr = {Addr[XLEN-1:2], 2'b00}
    - Bus_We = Mem_Write
    - Bus_Be and Bus_Wdata
    - Funct3 and Addr[1:0]
- REQ:
  - Bus_Req = 1 and Stall = 1.
  - All bus outputs stay stable until Bus_Ack = 1.
  - On Bus_Ack: for a load, capture and extend Bus_Rdata into Load_Data; go to DONE.
  - Counter increments each REQ cycle. If the count reaches TIMEOUT - 1 with no ack: Bus_Err pulses in DONE, Load_Data = 0, Load_Valid = 0.
- DONE:
  - One cycle. Stall = 0 so the core retires the instruction; Bus_Req = 0.
  - Load_Valid = 1 for a successful load.
  - Mem_Req is ignored in this cycle (it still belongs to the retiring instruction).
  - Next state is always IDLE; counter clears.
- Store lanes:
  - SB: Be = 0001 << Addr[1:0]; Wdata = byte replicated 4x.
  - SH: Be = 0011 << {Addr[1], 0}; Wdata = halfword replicated 2x.
  - SW: Be = 1111.
- Loads:
  - Bus_Be follows the same rules as stores.
  - LB/LBU select the byte lane by Addr[1:0]; LH/LHU select the halfword by Addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Funct3 011, 110, 111 are treated as word accesses.
- Latency with ack in the first REQ cycle: Stall high 2 cycles, result in cycle 3.
- A late ack extends REQ by one cycle per wait cycle.
- Reset asserted mid-transaction: Bus_Req drops immediately (asynchronous), the FSM returns to IDLE, and no Load_Valid or Bus_Err is produced.
- Bus_Ack outside REQ is ignored.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, when Mem_Req = 1 and the access is misaligned (halfword with Addr[0] = 1, or word with Addr[1:0] != 0), Misaligned = 1 combinationally.
  - No bus transaction is issued, Stall = 0, and the FSM stays in IDLE.
- Undefined:
  - Misaligned is tied to 0.
  - Misaligned halfword/word addresses have the offending low bits ignored: halfword uses Addr[1] only, word is forced aligned.

Test Plan:
- SW with Addr = 0x100, Store_Data = 0xDEADBEEF, ack in the first REQ cycle -> Bus_Addr = 0x100, Be = 1111, Wdata = 0xDEADBEEF, Bus_We = 1; Stall high 2 cycles.
- SB with Addr = 0x103, Store_Data = 0x000000A5 -> Be = 1000, Wdata = 0xA5A5A5A5, Bus_Addr = 0x100.
- LB with Addr = 0x102, Bus_Rdata = 0x12F08000, 3 wait cycles before ack -> Load_Data = 0xFFFFFFF0, Load_Valid one pulse, Stall high 5 cycles.
- LHU with Addr = 0x002, Bus_Rdata = 0x8001FFFF -> Load_Data = 0x00008001.
- Load with no ack, TIMEOUT = 16 -> Bus_Req high for 16 cycles, then Bus_Err pulse, Load_Valid = 0, Load_Data = 0.
- rst pulsed during REQ of an LW -> Bus_Req = 0 immediately, state IDLE, no Load_Valid. With MISALIGN_TRAP_EN: LW at 0x101 -> Misaligned = 1, Bus_Req stays 0.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: issues a req/ack data-bus transaction and stalls the core until it finishes.
// Optional MISALIGN_TRAP_EN flags misaligned halfword/word accesses in IDLE instead of issuing them.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            Mem_Req,
  input  logic            Mem_Write,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] Addr,
  input  logic [XLEN-1:0] Store_Data,
  output logic            Stall,
  output logic [XLEN-1:0] Load_Data,
  output logic            Load_Valid,
  output logic            Bus_Err,
  output logic            Misaligned,
  output logic            Bus_Req,
  output logic            Bus_We,
  output logic [XLEN-1:0] Bus_Addr,
  output logic [3:0]      Bus_Be,
  output logic [XLEN-1:0] Bus_Wdata,
  input  logic            Bus_Ack,
  input  logic [XLEN-1:0] Bus_Rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            trap;
  logic            start;
  logic [3:0]      be_nxt;
  logic [XLEN-1:0] wdata_nxt;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [XLEN-1:0] ext;

`ifdef MISALIGN_TRAP_EN
  logic mis;
  assign mis        = (Funct3[1:0] == 2'b01 && Addr[0]) || (Funct3[1] && Addr[1:0] != 2'b00);
  assign trap       = Mem_Req && mis;
  assign Misaligned = (state == IDLE) && trap;
`else
  assign trap       = 1'b0;
  assign Misaligned = 1'b0;
`endif

  assign start = (state == IDLE) && Mem_Req && !trap;

  // Lane placement; misaligned low address bits drop out of the shift amounts.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = Store_Data;
    case (Funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << Addr[1:0];
        wdata_nxt = {(XLEN/8){Store_Data[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << {Addr[1], 1'b0};
        wdata_nxt = {(XLEN/16){Store_Data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rbyte = Bus_Rdata[{off_q, 3'b000} +: 8];
    rhalf = Bus_Rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   ext = {{(XLEN-8){~f3_q[2] & rbyte[7]}}, rbyte};
      2'b01:   ext = {{(XLEN-16){~f3_q[2] & rhalf[15]}}, rhalf};
      default: ext = Bus_Rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    Stall     = 1'b0;
    Bus_Req   = 1'b0;
    case (state)
      IDLE: begin
        Stall = start;
        if (start) state_nxt = REQ;
      end
      REQ: begin
        Stall   = 1'b1;
        Bus_Req = 1'b1;
        if (Bus_Ack || cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      Bus_We     <= 1'b0;
      Bus_Be     <= '0;
      Bus_Addr   <= '0;
      Bus_Wdata  <= '0;
      Load_Data  <= '0;
      Load_Valid <= 1'b0;
      Bus_Err    <= 1'b0;
    end else begin
      Load_Valid <= 1'b0;
      Bus_Err    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start) begin
            Bus_Addr  <= {Addr[XLEN-1:2], 2'b00};
            Bus_We    <= Mem_Write;
            Bus_Be    <= be_nxt;
            Bus_Wdata <= wdata_nxt;
            f3_q      <= Funct3;
            off_q     <= Addr[1:0];
          end
        end
        REQ: begin
          if (Bus_Ack) begin
            if (!Bus_We) begin
              Load_Data  <= ext;
              Load_Valid <= 1'b1;
            end
          end else if (cnt == LAST) begin
            Bus_Err   <= 1'b1;
            Load_Data <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized transactions against an arithmetic lane model.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        rst;
  logic        Mem_Req, Mem_Write;
  logic [2:0]  Funct3;
  logic [31:0] Addr, Store_Data;
  logic        Stall, Load_Valid, Bus_Err, Misaligned, Bus_Req, Bus_We, Bus_Ack;
  logic [31:0] Load_Data, Bus_Addr, Bus_Wdata, Bus_Rdata;
  logic [3:0]  Bus_Be;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_ld   = '0;

  load_store_unit #(.XLEN(32), .TIMEOUT(16)) dut (
    .CLK(CLK), .rst(rst), .Mem_Req(Mem_Req), .Mem_Write(Mem_Write), .Funct3(Funct3),
    .Addr(Addr), .Store_Data(Store_Data), .Stall(Stall), .Load_Data(Load_Data),
    .Load_Valid(Load_Valid), .Bus_Err(Bus_Err), .Misaligned(Misaligned), .Bus_Req(Bus_Req),
    .Bus_We(Bus_We), .Bus_Addr(Bus_Addr), .Bus_Be(Bus_Be), .Bus_Wdata(Bus_Wdata),
    .Bus_Ack(Bus_Ack), .Bus_Rdata(Bus_Rdata)
  );

  always #5 CLK = ~CLK;

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata,
                         input int waits, input bit noack, input string name);
    int sz, off, stall_cnt, req_cnt, exp_req;
    bit seen, done;
    logic [31:0] ea, ew, v, mask;
    logic [3:0] eb;
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = int'(addr[1:0]);
    off = off - off % sz;
    ea  = addr & ~32'd3;
    eb  = 4'(((1 << sz) - 1) << off);
    ew  = (sz == 1) ? sdata[7:0] * 32'h01010101 : (sz == 2) ? sdata[15:0] * 32'h00010001 : sdata;
    v   = rdata >> (8 * off);
    if (sz < 4) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      v    = v & mask;
      if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    end
    exp_req = noack ? 16 : waits + 1;
    if (noack) exp_ld = '0;
    else if (!we) exp_ld = v;
    stall_cnt = 0; req_cnt = 0; seen = 0; done = 0;

    @(posedge CLK); #1;
    Mem_Req = 1'b1; Mem_Write = we; Funct3 = f3; Addr = addr; Store_Data = sdata; Bus_Ack = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (c == 0) begin
        n_checks++;
        if ({Misaligned, Stall, Bus_Req} !== 3'b010)
          begin n_fail++; $display("FAIL %s idle: mis/stall/req=%b want 010", name, {Misaligned, Stall, Bus_Req}); end
      end
      if (Stall) stall_cnt++;
      if (Bus_Req) begin
        seen = 1;
        n_checks++;
        if ({Bus_We, Bus_Be, Bus_Addr, Bus_Wdata, Load_Valid, Bus_Err} !== {we, eb, ea, ew, 2'b00})
          begin n_fail++; $display("FAIL %s bus: we=%b be=%b addr=%h wdata=%h lv/err=%b%b want we=%b be=%b addr=%h wdata=%h lv/err=00",
                                   name, Bus_We, Bus_Be, Bus_Addr, Bus_Wdata, Load_Valid, Bus_Err, we, eb, ea, ew); end
        Bus_Ack   = (!noack && req_cnt == waits);
        Bus_Rdata = Bus_Ack ? rdata : $urandom;
        req_cnt++;
      end else if (seen) begin
        done = 1;
        n_checks++;
        if ({Stall, Load_Valid, Bus_Err} !== {1'b0, !we && !noack, noack} || Load_Data !== exp_ld)
          begin n_fail++; $display("FAIL %s done: stall/lv/err=%b data=%h want %b data=%h", name,
                                   {Stall, Load_Valid, Bus_Err}, Load_Data, {1'b0, !we && !noack, noack}, exp_ld); end
        n_checks++;
        if (req_cnt !== exp_req || stall_cnt !== exp_req + 1)
          begin n_fail++; $display("FAIL %s timing: req=%0d stall=%0d want req=%0d stall=%0d", name,
                                   req_cnt, stall_cnt, exp_req, exp_req + 1); end
        Bus_Ack = 1'($urandom_range(0, 1));
      end else begin
        Bus_Ack   = 1'($urandom_range(0, 1));
        Bus_Rdata = $urandom;
      end
      if (!done) begin @(posedge CLK); #1; end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s budget: no completion after 40 cycles, req=%0d", name, req_cnt);
    end
    @(posedge CLK); #1;
    n_checks++;
    if ({Bus_Req, Load_Valid, Bus_Err} !== 3'b000)
      begin n_fail++; $display("FAIL %s after: req/lv/err=%b want 000", name, {Bus_Req, Load_Valid, Bus_Err}); end
    Mem_Req = 1'b0; Bus_Ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; Mem_Req = 0; Mem_Write = 0; Funct3 = 0; Addr = 0; Store_Data = 0;
    Bus_Ack = 0; Bus_Rdata = 0;
    #12;
    n_checks++;
    if ({Bus_Req, Bus_We, Bus_Be, Bus_Addr, Bus_Wdata, Load_Data, Load_Valid, Bus_Err, Misaligned, Stall} !== '0)
      begin n_fail++; $display("FAIL reset_values: req=%b we=%b be=%b addr=%h wdata=%h ld=%h lv=%b err=%b mis=%b stall=%b want all 0",
                               Bus_Req, Bus_We, Bus_Be, Bus_Addr, Bus_Wdata, Load_Data, Load_Valid, Bus_Err, Misaligned, Stall); end
    @(posedge CLK); #1; rst = 1'b0;
    exp_ld = '0;
  endtask

  task automatic test_directed;
    run_txn(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, "sw_100");
    run_txn(1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, "sb_103");
    run_txn(0, 3'b000, 32'h102, 32'h0, 32'h12F08000, 3, 0, "lb_102");
    n_checks++;
    if (exp_ld !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL lb_model: got %h want FFFFFFF0", exp_ld); end
    run_txn(0, 3'b101, 32'h002, 32'h0, 32'h8001FFFF, 0, 0, "lhu_002");
    run_txn(1, 3'b001, 32'h0FE, 32'hCAFE1234, 32'h0, 1, 0, "sh_0fe");
    run_txn(0, 3'b001, 32'h0FE, 32'h0, 32'h9ABC0000, 2, 0, "lh_0fe");
    run_txn(0, 3'b010, 32'h040, 32'h0, 32'h0, 0, 1, "lw_timeout");
    run_txn(0, 3'b110, 32'h044, 32'h0, 32'h76543210, 0, 0, "f3_110_word");
  endtask

  task automatic test_reset_mid_txn;
    @(posedge CLK); #1;
    Mem_Req = 1'b1; Mem_Write = 1'b0; Funct3 = 3'b010; Addr = 32'h200; Bus_Ack = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if (Bus_Req !== 1'b1) begin n_fail++; $display("FAIL rst_mid pre: req=%b want 1", Bus_Req); end
    rst = 1'b1; #1;
    n_checks++;
    if ({Bus_Req, Bus_Be, Bus_Addr, Load_Valid, Bus_Err, Load_Data} !== '0)
      begin n_fail++; $display("FAIL rst_mid async: req=%b be=%b addr=%h lv=%b err=%b ld=%h want 0",
                               Bus_Req, Bus_Be, Bus_Addr, Load_Valid, Bus_Err, Load_Data); end
    Mem_Req = 1'b0; exp_ld = '0;
    @(posedge CLK); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      n_checks++;
      if ({Bus_Req, Load_Valid, Bus_Err, Stall} !== 4'b0000)
        begin n_fail++; $display("FAIL rst_mid post%0d: req/lv/err/stall=%b want 0000", i, {Bus_Req, Load_Valid, Bus_Err, Stall}); end
    end
    run_txn(0, 3'b010, 32'h204, 32'h0, 32'h13579BDF, 0, 0, "lw_after_rst");
  endtask

`ifdef MISALIGN_TRAP_EN
  task automatic test_misalign;
    @(posedge CLK); #1;
    Mem_Req = 1'b1; Mem_Write = 1'b0; Funct3 = 3'b010; Addr = 32'h101; #1;
    n_checks++;
    if ({Misaligned, Stall} !== 2'b10) begin n_fail++; $display("FAIL trap_lw: mis/stall=%b want 10", {Misaligned, Stall}); end
    @(posedge CLK); #1;
    Funct3 = 3'b001; Addr = 32'h103; #1;
    n_checks++;
    if ({Misaligned, Stall, Bus_Req} !== 3'b100)
      begin n_fail++; $display("FAIL trap_lh: mis/stall/req=%b want 100", {Misaligned, Stall, Bus_Req}); end
    Mem_Req = 1'b0;
    @(posedge CLK); #1;
    n_checks++;
    if (Bus_Req !== 1'b0) begin n_fail++; $display("FAIL trap_noreq: req=%b want 0", Bus_Req); end
    run_txn(0, 3'b000, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, "lb_103_ok");
  endtask
`else
  task automatic test_misalign;
    run_txn(0, 3'b010, 32'h101, 32'h0, 32'hA1B2C3D4, 1, 0, "lw_101_forced");
    run_txn(1, 3'b001, 32'h103, 32'h0000BEEF, 32'h0, 0, 0, "sh_103_forced");
  endtask
`endif

  task automatic test_random;
    logic [2:0] f3;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
`ifdef MISALIGN_TRAP_EN
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      else if (f3[1]) a[1:0] = 2'b00;
`endif
      run_txn(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom, $urandom_range(0, 4), 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_txn();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
